// File: rtl/fduart_tx_arbiter.sv
// Round-robin, message-atomic arbiter that shares the fduart TX FIFO
// among NUM_REQ byte-stream requesters, pacing writes against FIFO full.
module fduart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   sysclk,
  input  logic                   sysreset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_pulse,
  input  logic                   atx_fifo_full,
  output logic [15:0]            data_out,
  output logic                   atx_reg_load
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [WW-1:0] TLIM =
    WW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef logic [NUM_REQ-1:0] req_t;
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        r_state, w_state;
  req_t          r_grant, w_grant;
  logic [PW-1:0] r_owner, w_owner;
  logic [PW-1:0] r_ptr, w_ptr;
  logic [1:0]    r_hold, w_hold;
  logic [WW-1:0] r_wdog, w_wdog;
  logic          r_load, w_load;
  logic [7:0]    r_data, w_data;
  logic          r_tout, w_tout;

  logic [PW-1:0] w_sel;
  req_t          w_sel_oh;
  logic          w_any;
  logic          w_own_valid;
  logic          w_own_last;
  logic [7:0]    w_own_byte;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_open;
  logic          w_accept;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [PW:0] v_sum;
    logic        v_found;
    v_found = 1'b0;
    v_sum   = '0;
    w_sel   = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (v_sum >= (PW+1)'(NUM_REQ))
        v_sum = v_sum - (PW+1)'(NUM_REQ);
      if (!v_found && req_valid[v_sum[PW-1:0]]) begin
        v_found = 1'b1;
        w_sel   = v_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PW'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_byte  = req_data[8*i +: 8];
      end
    end
  end

  assign w_any     = |req_valid;
  assign w_sel_oh  = req_t'(1) << w_sel;
  assign w_ptr_nxt = (r_owner == PW'(NUM_REQ - 1)) ? '0
                   : r_owner + 1'b1;
  assign w_open    = (r_state == S_SEND) && !atx_fifo_full
                   && (r_hold == 2'd0);
  assign w_accept  = w_open && w_own_valid;

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_owner = r_owner;
    w_ptr   = r_ptr;
    w_hold  = (r_hold != 2'd0) ? r_hold - 2'd1 : 2'd0;
    w_wdog  = r_wdog;
    w_load  = 1'b0;
    w_data  = r_data;
    w_tout  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state = S_SEND;
          w_grant = w_sel_oh;
          w_owner = w_sel;
          w_wdog  = '0;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_load = 1'b1;
          w_data = w_own_byte;
          w_hold = 2'd2;
          w_wdog = '0;
          if (w_own_last) begin
            w_state = S_IDLE;
            w_grant = '0;
            w_ptr   = w_ptr_nxt;
          end
        end else if (!w_own_valid && IDLE_TIMEOUT > 0) begin
          // Only an owner with nothing to offer counts toward revocation.
          if (r_wdog == TLIM) begin
            w_tout  = 1'b1;
            w_state = S_IDLE;
            w_grant = '0;
            w_ptr   = w_ptr_nxt;
            w_wdog  = '0;
          end else begin
            w_wdog = r_wdog + 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_wdog  <= '0;
      r_load  <= 1'b0;
      r_data  <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
      r_wdog  <= w_wdog;
      r_load  <= w_load;
      r_data  <= w_data;
      r_tout  <= w_tout;
    end
  end

  assign req_ready     = w_open ? r_grant : '0;
  assign grant         = r_grant;
  assign busy          = (r_state == S_SEND);
  assign timeout_pulse = r_tout;
  assign data_out      = {8'h00, r_data};
  assign atx_reg_load  = r_load;

endmodule
